// File: rtl/int0_pkg.sv
// Shared Int0 lane types: issuer state encoding and destination/token field layout.
package int0_pkg;

    localparam int unsigned NodeW = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StEmitT = 2'b01,
        StEmitF = 2'b10
    } tis_state_e;

    // One destination; a token is laid out as {node, lr, uni_opr, data}.
    typedef struct packed {
        logic [NodeW-1:0] node;
        logic             lr;
        logic             uni_opr;
    } tis_dest_t;

    localparam int unsigned DestW = $bits(tis_dest_t);

endpackage

// File: rtl/tis_counter.sv
// Wrapping statistics counter with enable and synchronous active-high reset.
module tis_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Increment on enable; natural overflow gives the wrap to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/token_issuer.sv
// Serialises one resolved destination set into zero, one or two result tokens.
module token_issuer
    import int0_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i_tis,
    input  logic              rst_i_tis,
    input  logic              in_valid_i_tis,
    output logic              in_ack_o_tis,
    input  logic [NodeW-1:0]  t_node_i_tis,
    input  logic              t_lr_i_tis,
    input  logic              t_uni_opr_i_tis,
    input  logic [NodeW-1:0]  f_node_i_tis,
    input  logic              f_lr_i_tis,
    input  logic              f_uni_opr_i_tis,
    input  logic              cp_i_tis,
    input  logic              terminate_i_tis,
    input  logic [DATA_W-1:0] data_i_tis,
    output logic              out_valid_o_tis,
    input  logic              out_ack_i_tis,
    output logic [NodeW-1:0]  out_node_o_tis,
    output logic              out_lr_o_tis,
    output logic              out_uni_opr_o_tis,
    output logic [DATA_W-1:0] out_data_o_tis,
    output logic              out_last_o_tis,
    output logic              term_o_tis,
    output logic [CNT_W-1:0]  issued_cnt_o_tis,
    output logic [CNT_W-1:0]  term_cnt_o_tis
);

    tis_state_e        state_d, state_q;
    logic              out_valid_d, out_valid_q;
    logic              out_last_d, out_last_q;
    tis_dest_t         out_dest_d, out_dest_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    tis_dest_t         f_dest_d, f_dest_q;
    logic              term_d, term_q;

    logic out_hs;
    logic in_ack;
    logic in_hs;
    logic term_hs;

    assign out_hs  = out_valid_q & out_ack_i_tis;
    // Accept when idle, or when the final token of the current set leaves this cycle.
    assign in_ack  = (state_q == StIdle) | ((state_q != StIdle) & out_hs & out_last_q);
    assign in_hs   = in_valid_i_tis & in_ack;
    assign term_hs = in_hs & terminate_i_tis;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_dest_d  = out_dest_q;
        out_data_d  = out_data_q;
        f_dest_d    = f_dest_q;
        term_d      = 1'b0;

        unique case (state_q)
            StEmitT: begin
                if (out_hs) begin
                    // In EMIT_T, out_last is the inverse of the captured copy flag.
                    if (!out_last_q) begin
                        state_d    = StEmitF;
                        out_dest_d = f_dest_q;
                        out_last_d = 1'b1;
                    end else begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                    end
                end
            end
            StEmitF: begin
                if (out_hs) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A capture overrides completion so back-to-back sets have no bubble.
        if (in_hs) begin
            f_dest_d = '{node: f_node_i_tis, lr: f_lr_i_tis, uni_opr: f_uni_opr_i_tis};
            if (terminate_i_tis) begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                term_d      = 1'b1;
            end else begin
                state_d     = StEmitT;
                out_valid_d = 1'b1;
                out_last_d  = ~cp_i_tis;
                out_dest_d  = '{node: t_node_i_tis, lr: t_lr_i_tis, uni_opr: t_uni_opr_i_tis};
                out_data_d  = data_i_tis;
            end
        end
    end

    // FSM state, holding register and registered outputs.
    always_ff @(posedge clk_i_tis) begin
        if (rst_i_tis) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_dest_q  <= '0;
            out_data_q  <= '0;
            f_dest_q    <= '0;
            term_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_dest_q  <= out_dest_d;
            out_data_q  <= out_data_d;
            f_dest_q    <= f_dest_d;
            term_q      <= term_d;
        end
    end

    tis_counter #(
        .CNT_W (CNT_W)
    ) u_issued_cnt (
        .clk_i (clk_i_tis),
        .rst_i (rst_i_tis),
        .en_i  (out_hs),
        .cnt_o (issued_cnt_o_tis)
    );

    tis_counter #(
        .CNT_W (CNT_W)
    ) u_term_cnt (
        .clk_i (clk_i_tis),
        .rst_i (rst_i_tis),
        .en_i  (term_hs),
        .cnt_o (term_cnt_o_tis)
    );

    assign in_ack_o_tis      = in_ack;
    assign out_valid_o_tis   = out_valid_q;
    assign out_node_o_tis    = out_dest_q.node;
    assign out_lr_o_tis      = out_dest_q.lr;
    assign out_uni_opr_o_tis = out_dest_q.uni_opr;
    assign out_data_o_tis    = out_data_q;
    assign out_last_o_tis    = out_last_q;
    assign term_o_tis        = term_q;

endmodule

// File: tb/tb_token_issuer.sv
// Bench for token_issuer: token-queue reference model plus directed literal checks.
module tb_token_issuer;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ack;
    logic [15:0]   t_node = '0;
    logic          t_lr = 1'b0;
    logic          t_uni = 1'b0;
    logic [15:0]   f_node = '0;
    logic          f_lr = 1'b0;
    logic          f_uni = 1'b0;
    logic          cp = 1'b0;
    logic          terminate = 1'b0;
    logic [DW-1:0] data = '0;
    logic          out_valid;
    logic          out_ack = 1'b0;
    logic [15:0]   out_node;
    logic          out_lr;
    logic          out_uni;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          term;
    logic [CW-1:0] issued_cnt;
    logic [CW-1:0] term_cnt;

    always #5 clk = ~clk;

    token_issuer #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk_i_tis         (clk),
        .rst_i_tis         (rst),
        .in_valid_i_tis    (in_valid),
        .in_ack_o_tis      (in_ack),
        .t_node_i_tis      (t_node),
        .t_lr_i_tis        (t_lr),
        .t_uni_opr_i_tis   (t_uni),
        .f_node_i_tis      (f_node),
        .f_lr_i_tis        (f_lr),
        .f_uni_opr_i_tis   (f_uni),
        .cp_i_tis          (cp),
        .terminate_i_tis   (terminate),
        .data_i_tis        (data),
        .out_valid_o_tis   (out_valid),
        .out_ack_i_tis     (out_ack),
        .out_node_o_tis    (out_node),
        .out_lr_o_tis      (out_lr),
        .out_uni_opr_o_tis (out_uni),
        .out_data_o_tis    (out_data),
        .out_last_o_tis    (out_last),
        .term_o_tis        (term),
        .issued_cnt_o_tis  (issued_cnt),
        .term_cnt_o_tis    (term_cnt)
    );

    typedef struct {
        logic [15:0]   node;
        logic          lr;
        logic          uni;
        logic [DW-1:0] data;
        logic          last;
    } tok_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: tokens still owed to the router, in order.
    tok_t        q[$];
    bit          model_on = 0;
    bit          fields_zero = 0;
    logic        exp_term = 1'b0;
    int unsigned exp_issued = 0;
    int unsigned exp_tcnt = 0;
    logic        m_iack;
    tok_t        m_tok;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare every cycle at the negedge, then advance the model across the next posedge.
    always @(negedge clk) begin
        m_iack = (q.size() == 0) || (q.size() == 1 && out_ack);
        if (model_on) begin
            chk("m_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("m_out_node", out_node, q[0].node);
                chk("m_out_lr", out_lr, q[0].lr);
                chk("m_out_uni", out_uni, q[0].uni);
                chk("m_out_data", out_data, q[0].data);
                chk("m_out_last", out_last, q[0].last);
            end else if (fields_zero) begin
                chk("m_zero_node", out_node, 0);
                chk("m_zero_data", out_data, 0);
                chk("m_zero_last", out_last, 0);
            end
            chk("m_in_ack", in_ack, m_iack);
            chk("m_term", term, exp_term);
            chk("m_issued_cnt", issued_cnt, exp_issued);
            chk("m_term_cnt", term_cnt, exp_tcnt);
        end
        if (rst) begin
            q.delete();
            exp_term    = 1'b0;
            exp_issued  = 0;
            exp_tcnt    = 0;
            model_on    = 1;
            fields_zero = 1;
        end else if (model_on) begin
            exp_term = 1'b0;
            if (q.size() != 0 && out_ack) begin
                void'(q.pop_front());
                exp_issued = (exp_issued + 1) % (1 << CW);
            end
            if (in_valid && m_iack) begin
                fields_zero = 0;
                if (terminate) begin
                    exp_term = 1'b1;
                    exp_tcnt = (exp_tcnt + 1) % (1 << CW);
                end else begin
                    m_tok = '{node: t_node, lr: t_lr, uni: t_uni, data: data, last: !cp};
                    q.push_back(m_tok);
                    if (cp) begin
                        m_tok = '{node: f_node, lr: f_lr, uni: f_uni, data: data, last: 1'b1};
                        q.push_back(m_tok);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] tn, input logic tl, input logic tu,
                         input logic [15:0] fn, input logic fl, input logic fu,
                         input logic c, input logic tm, input logic [DW-1:0] d);
        t_node    = tn;
        t_lr      = tl;
        t_uni     = tu;
        f_node    = fn;
        f_lr      = fl;
        f_uni     = fu;
        cp        = c;
        terminate = tm;
        data      = d;
        in_valid  = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_term", term, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_out_node", out_node, 0);
        rst = 1'b0;

        // Single token, no stall.
        out_ack = 1'b1;
        drive(16'h0104, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_in_ack", in_ack, 1);
        step();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_node", out_node, 16'h0104);
        chk("t1_lr", out_lr, 1);
        chk("t1_last", out_last, 1);
        chk("t1_data", out_data, 32'hDEAD_BEEF);
        step();
        chk("t1_idle", out_valid, 0);
        chk("t1_issued", issued_cnt, 1);

        // Copy: true token then false token with the same data.
        drive(16'h0010, 1'b0, 1'b0, 16'h0020, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
        step();
        in_valid = 1'b0;
        chk("t2_node_t", out_node, 16'h0010);
        chk("t2_last_t", out_last, 0);
        chk("t2_in_ack_t", in_ack, 0);
        step();
        chk("t2_node_f", out_node, 16'h0020);
        chk("t2_lr_f", out_lr, 1);
        chk("t2_uni_f", out_uni, 1);
        chk("t2_last_f", out_last, 1);
        chk("t2_data_f", out_data, 32'h1234_5678);
        chk("t2_in_ack_f", in_ack, 1);
        step();
        chk("t2_idle", out_valid, 0);
        chk("t2_issued", issued_cnt, 3);

        // Terminate beats copy: nothing emitted, one-cycle pulse.
        drive(16'h0030, 1'b0, 1'b0, 16'h0031, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0055);
        step();
        in_valid = 1'b0;
        chk("t3_valid", out_valid, 0);
        chk("t3_term", term, 1);
        chk("t3_term_cnt", term_cnt, 1);
        step();
        chk("t3_term_off", term, 0);
        chk("t3_valid2", out_valid, 0);
        chk("t3_issued", issued_cnt, 3);

        // Stall during a copy's true token.
        out_ack = 1'b0;
        drive(16'h0AAA, 1'b0, 1'b1, 16'h0BBB, 1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_node", out_node, 16'h0AAA);
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_in_ack", in_ack, 0);
            step();
        end
        out_ack = 1'b1;
        chk("t4_hold_node", out_node, 16'h0AAA);
        step();
        chk("t4_node_f", out_node, 16'h0BBB);
        chk("t4_lr_f", out_lr, 1);
        chk("t4_uni_f", out_uni, 0);
        chk("t4_last_f", out_last, 1);
        chk("t4_data_f", out_data, 32'hCAFE_F00D);
        step();
        chk("t4_idle", out_valid, 0);
        chk("t4_issued", issued_cnt, 5);

        // Back-to-back streaming: a new token every cycle.
        for (int i = 0; i < 8; i++) begin
            drive(16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'(i));
            step();
            chk("t5_stream_node", out_node, 16'h0100 + 16'(i));
            chk("t5_stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        step();
        chk("t5_idle", out_valid, 0);
        chk("t5_issued", issued_cnt, 13);

        // Reset clears the counters.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_issued", issued_cnt, 0);
        chk("t6_term_cnt", term_cnt, 0);
        chk("t6_valid", out_valid, 0);

        // Wrap: 65536 captures yield 65535 handshakes, one more wraps to zero.
        drive(16'h0200, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5);
        repeat (65536) @(posedge clk);
        #1;
        chk("t7_issued_max", issued_cnt, 16'hFFFF);
        in_valid = 1'b0;
        step();
        chk("t7_issued_wrap", issued_cnt, 0);
        chk("t7_idle", out_valid, 0);

        // Reset during EMIT_F discards the outstanding false token.
        drive(16'h0300, 1'b0, 1'b0, 16'h0301, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0077);
        step();
        in_valid = 1'b0;
        chk("t8_node_t", out_node, 16'h0300);
        step();
        chk("t8_node_f", out_node, 16'h0301);
        chk("t8_valid_f", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t8_rst_valid", out_valid, 0);
        chk("t8_rst_issued", issued_cnt, 0);
        chk("t8_rst_node", out_node, 0);
        chk("t8_rst_last", out_last, 0);
        step();
        chk("t8_discarded", out_valid, 0);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
